// File: rtl/vec_mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// vec_mux_arb_pkg
//  Shared definitions for the vec_mux_arb stream multiplexer:
//   - select-mode encodings (fixed select / round-robin)
//   - default WIDTH / NCH / SELW values
//   - even-parity helper used when VEC_MUX_PARITY_EN is defined
// ---------------------------------------------------------------------------
package vec_mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_SELW  = 2;

    // XOR-reduction parity of a word of up to 64 bits. Unused upper bits
    // are zero, so they do not change the result.
    function automatic logic even_par(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//  NCH-wide rotating-priority arbiter. It owns the round-robin pointer:
//  the search starts at ptr and scans ptr, ptr+1, ... modulo NCH. When en
//  is high (a grant was accepted in round-robin mode) the pointer moves to
//  the channel after the granted one, wrapping NCH-1 -> 0.
//
//  Ports
//   clk   in   1      clock, rising edge
//   rst   in   1      asynchronous active-high reset (ptr -> 0)
//   req   in   NCH    request vector (per-channel valid)
//   en    in   1      advance the pointer past the current grant
//   gnt   out  NCH    one-hot grant, or zero when nothing requests
//   idx   out  SELW   encoded index of the granted channel
//   ptr   out  SELW   current round-robin pointer
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic            en,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] idx,
    output logic [SELW-1:0] ptr
);

    logic [SELW-1:0] r_ptr;
    logic [NCH-1:0]  w_gnt;
    logic [SELW-1:0] w_idx;
    logic            w_found;
    logic [SELW-1:0] w_next_ptr;
    int              w_pos;

    // Rotating scan: offset k maps to channel (ptr + k) mod NCH. The inner
    // loop compares against constant channel numbers so every index into
    // req is a compile-time constant.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NCH; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= NCH) begin
                w_pos = w_pos - NCH;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!w_found && (i == w_pos) && req[i]) begin
                    w_gnt[i] = 1'b1;
                    w_idx    = SELW'(i);
                    w_found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (w_idx == SELW'(NCH - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign gnt = w_gnt;
    assign idx = w_idx;
    assign ptr = r_ptr;

endmodule

// File: rtl/vec_mux_arb.sv
// ---------------------------------------------------------------------------
// vec_mux_arb
//  NCH-input, WIDTH-bit registered stream multiplexer with valid/ready
//  handshakes. mode=0 picks the channel given by sel; mode=1 uses the
//  rr_arbiter rotating-priority grant. One output register stage gives one
//  word per clock while out_ready stays high.
//
//  Handshake: a word moves on a port in any cycle where its valid and ready
//  are both high; valid must not depend on ready, and a held output word
//  (out_valid=1, out_ready=0) stays stable until taken.
//
//  Optional feature macro: VEC_MUX_PARITY_EN adds out_par, the XOR parity
//  of the accepted word, registered with out_data.
//
//  Ports
//   clk        in   1          clock, rising edge
//   reset      in   1          asynchronous active-high reset
//   mode       in   1          0 = fixed select, 1 = round-robin
//   sel        in   SELW       channel select (mode=0 only)
//   in_data    in   NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NCH        per-channel valid
//   in_ready   out  NCH        per-channel ready, one-hot or zero
//   out_data   out  WIDTH      registered selected data
//   out_chan   out  SELW       channel index of out_data
//   out_valid  out  1          out_data/out_chan valid
//   out_ready  in   1          downstream ready
//   out_par    out  1          parity of out_data (VEC_MUX_PARITY_EN only)
//   dbg_rr_ptr out  SELW       round-robin pointer, for observation
// ---------------------------------------------------------------------------
module vec_mux_arb
    import vec_mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = DEF_SELW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef VEC_MUX_PARITY_EN
    output logic                 out_par,
`endif
    output logic [SELW-1:0]      dbg_rr_ptr
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;

    logic             w_load;
    logic [NCH-1:0]   w_fix_gnt;
    logic [NCH-1:0]   w_rr_gnt;
    logic [SELW-1:0]  w_rr_idx;
    logic [NCH-1:0]   w_gnt;
    logic [SELW-1:0]  w_gidx;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_accept;
    logic             w_rr_en;

    // The output register can take a new word when it is empty or its
    // current word leaves this cycle. Reset blocks acceptance so no input
    // word is consumed while the register is being cleared.
    assign w_load = (!r_out_valid || out_ready) && !reset;

    // Fixed-select grant. A sel value at or beyond NCH matches no channel,
    // so the grant is zero and nothing is accepted.
    always_comb begin
        w_fix_gnt = '0;
        for (int i = 0; i < NCH; i++) begin
            w_fix_gnt[i] = (int'(sel) == i) && in_valid[i];
        end
    end

    assign w_gnt    = (mode == MODE_RR) ? w_rr_gnt : w_fix_gnt;
    assign w_gidx   = (mode == MODE_RR) ? w_rr_idx : sel;
    assign in_ready = w_gnt & {NCH{w_load}};
    assign w_accept = |(in_valid & in_ready);
    assign w_rr_en  = w_accept && (mode == MODE_RR);

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .clk (clk),
        .rst (reset),
        .req (in_valid),
        .en  (w_rr_en),
        .gnt (w_rr_gnt),
        .idx (w_rr_idx),
        .ptr (dbg_rr_ptr)
    );

    // Data mux driven by the granted index; constant slice bounds only.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(w_gidx) == i) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_gidx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef VEC_MUX_PARITY_EN
    logic r_out_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_par <= 1'b0;
        end else if (w_accept) begin
            r_out_par <= even_par(64'(w_sel_data));
        end
    end

    assign out_par = r_out_par;
`endif

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_vec_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_vec_mux_arb
//  Directed bench for vec_mux_arb (WIDTH=8, NCH=4, SELW=3 so that an
//  out-of-range select can be driven). Inputs change 1 time unit after a
//  rising edge; outputs are sampled there too, away from the edge.
// ---------------------------------------------------------------------------
module tb_vec_mux_arb;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 3;

    logic                 clk;
    logic                 reset;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      dbg_rr_ptr;
`ifdef VEC_MUX_PARITY_EN
    logic                 out_par;
`endif

    int checks   = 0;
    int failures = 0;

    vec_mux_arb #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef VEC_MUX_PARITY_EN
        .out_par    (out_par),
`endif
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel payloads: ch0=11, ch1=22, ch2=A5, ch3=44.
    function automatic logic [7:0] ch_data(input int c);
        case (c)
            0: return 8'h11;
            1: return 8'h22;
            2: return 8'hA5;
            default: return 8'h44;
        endcase
    endfunction

    int seq_all [5] = '{0, 1, 2, 3, 0};
    int seq_alt [4] = '{1, 3, 1, 3};

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
        in_valid  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_chan", 32'(out_chan), 32'd0);
        chk("rst_ptr", 32'(dbg_rr_ptr), 32'd0);

        // Fixed mode, sel=2.
        mode      = 1'b0;
        sel       = 3'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("fix_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("fix_valid", 32'(out_valid), 32'd1);
        chk("fix_data", 32'(out_data), 32'hA5);
        chk("fix_chan", 32'(out_chan), 32'd2);
        chk("fix_ptr", 32'(dbg_rr_ptr), 32'd0);

        // Out-of-range select: no grant, register drains.
        sel = 3'd5;
        #1;
        chk("oor_ready", 32'(in_ready), 32'd0);
        tick();
        chk("oor_valid", 32'(out_valid), 32'd0);

        // Round-robin, all valid.
        mode = 1'b1;
        #1;
        chk("rr_ready0", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_all_chan", 32'(out_chan), 32'(seq_all[k]));
            chk("rr_all_data", 32'(out_data), 32'(ch_data(seq_all[k])));
        end
        chk("rr_all_ptr", 32'(dbg_rr_ptr), 32'd1);

        // Round-robin, channels 1 and 3 only.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_alt_chan", 32'(out_chan), 32'(seq_alt[k]));
        end
        chk("rr_alt_ptr", 32'(dbg_rr_ptr), 32'd0);

        // Backpressure.
        in_valid = 4'b1111;
        tick();
        chk("bp_first_chan", 32'(out_chan), 32'd0);
        chk("bp_first_ptr", 32'(dbg_rr_ptr), 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                mode = 1'b0;
                sel  = 3'd3;
            end else begin
                mode = 1'b1;
            end
            #1;
            chk("bp_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h11);
            chk("bp_chan", 32'(out_chan), 32'd0);
            chk("bp_ptr", 32'(dbg_rr_ptr), 32'd1);
        end
        mode      = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("bp_release_chan", 32'(out_chan), 32'd1);
        chk("bp_release_data", 32'(out_data), 32'h22);
        chk("bp_release_ptr", 32'(dbg_rr_ptr), 32'd2);

        // Mode switch mid-stream.
        mode = 1'b0;
        sel  = 3'd0;
        #1;
        chk("sw_fix_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("sw_fix_chan", 32'(out_chan), 32'd0);
        chk("sw_fix_ptr", 32'(dbg_rr_ptr), 32'd2);
        mode = 1'b1;
        #1;
        chk("sw_rr_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("sw_rr_chan", 32'(out_chan), 32'd2);
        chk("sw_rr_data", 32'(out_data), 32'hA5);
        chk("sw_rr_ptr", 32'(dbg_rr_ptr), 32'd3);

        // Reset while a word is held.
        out_ready = 1'b0;
        #1;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_data", 32'(out_data), 32'd0);
        chk("mid_chan", 32'(out_chan), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd0);
        chk("mid_ptr", 32'(dbg_rr_ptr), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef VEC_MUX_PARITY_EN
        mode      = 1'b0;
        sel       = 3'd0;
        out_ready = 1'b1;
        in_data   = {8'h44, 8'hA5, 8'h22, 8'h07};
        tick();
        chk("par_data07", 32'(out_data), 32'h07);
        chk("par_07", 32'(out_par), 32'd1);
        in_data   = {8'h44, 8'hA5, 8'h22, 8'h03};
        tick();
        chk("par_data03", 32'(out_data), 32'h03);
        chk("par_03", 32'(out_par), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
